// File: rtl/morty_hazard_ctrl.sv
// morty_hazard_ctrl: sole source of pipeline stall/clear controls (load-use, branch, MC op, mem wait, trap).
// Define HAZARD_PERF_EN to build the stall/flush performance counters; otherwise they read as zero.
module morty_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_TIMEOUT   = 64,
    parameter int PERF_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic [4:0]        ex_rd_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_branch_taken_i,
    input  logic              ex_mc_start_i,
    input  logic              mc_done_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    input  logic              trap_req_i,
    output logic              stall_pc_o,
    output logic              stall_ifid_o,
    output logic              stall_idex_o,
    output logic              stall_exmem_o,
    output logic              clear_ifid_o,
    output logic              clear_idex_o,
    output logic              clear_exmem_o,
    output logic              clear_memwb_o,
    output logic              mc_kill_o,
    output logic              mc_timeout_o,
    output logic [PERF_W-1:0] perf_stall_cnt_o,
    output logic [PERF_W-1:0] perf_flush_cnt_o
);
    // state        | meaning
    // S_RUN        | normal flow; only branch squash / load-use bubble
    // S_MEM_WAIT   | data memory access outstanding, freeze up to EX/MEM
    // S_MC_WAIT    | multi-cycle EX op running, freeze up to ID/EX
    // S_TRAP_FLUSH | flushing front of pipe after a trap
    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_MC_WAIT, S_TRAP_FLUSH} state_e;

    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES);
    localparam logic [7:0] MC_LAST    = 8'(MC_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] mc_cnt_q, mc_cnt_d;
    logic [7:0] flush_cnt_q, flush_cnt_d;

    logic       in_flush, mem_wait, mc_pend, mc_expire, mc_wait;
    logic       run_free, load_use, br_act, lu_act;
    logic [7:0] mc_num;

    assign in_flush  = (state_q == S_TRAP_FLUSH);
    assign mem_wait  = !trap_req_i && !in_flush &&
                       ((state_q == S_MEM_WAIT) ? !mem_ack_i : (mem_req_i && !mem_ack_i));
    // mc_num is the wait-cycle number of the current cycle; entry cycle counts as 1
    assign mc_pend   = !trap_req_i && !in_flush && !mem_wait &&
                       ((state_q == S_MC_WAIT) ? !mc_done_i : (ex_mc_start_i && !mc_done_i));
    assign mc_num    = (state_q == S_MC_WAIT) ? mc_cnt_q : 8'd1;
    assign mc_expire = mc_pend && (mc_num >= MC_LAST);
    assign mc_wait   = mc_pend && !mc_expire;

    assign load_use  = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                       ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                        (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
    assign run_free  = !trap_req_i && !in_flush && !mem_wait && !mc_wait;
    assign br_act    = run_free && ex_branch_taken_i;
    assign lu_act    = run_free && !ex_branch_taken_i && load_use;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_RUN;
            mc_cnt_q    <= 8'd0;
            flush_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = S_RUN;
        mc_cnt_d    = mc_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (trap_req_i) begin
            flush_cnt_d = 8'd1;
            state_d     = (FLUSH_LAST <= 8'd1) ? S_RUN : S_TRAP_FLUSH;
        end else if (in_flush) begin
            flush_cnt_d = flush_cnt_q + 8'd1;
            state_d     = (flush_cnt_d >= FLUSH_LAST) ? S_RUN : S_TRAP_FLUSH;
        end else if (mem_wait) begin
            state_d = S_MEM_WAIT;
        end else if (mc_wait) begin
            mc_cnt_d = mc_num + 8'd1;
            state_d  = S_MC_WAIT;
        end
    end

    always_comb begin
        stall_pc_o    = 1'b0;
        stall_ifid_o  = 1'b0;
        stall_idex_o  = 1'b0;
        stall_exmem_o = 1'b0;
        clear_ifid_o  = 1'b0;
        clear_idex_o  = 1'b0;
        clear_exmem_o = 1'b0;
        clear_memwb_o = 1'b0;
        mc_kill_o     = 1'b0;
        mc_timeout_o  = 1'b0;
        if (rst_i) begin
            clear_ifid_o  = 1'b1;
            clear_idex_o  = 1'b1;
            clear_exmem_o = 1'b1;
            clear_memwb_o = 1'b1;
        end else begin
            if (trap_req_i || in_flush) begin
                clear_ifid_o  = 1'b1;
                clear_idex_o  = 1'b1;
                clear_exmem_o = 1'b1;
            end
            if (mem_wait) begin
                stall_pc_o    = 1'b1;
                stall_ifid_o  = 1'b1;
                stall_idex_o  = 1'b1;
                stall_exmem_o = 1'b1;
                clear_memwb_o = 1'b1;
            end
            if (mc_wait) begin
                stall_pc_o    = 1'b1;
                stall_ifid_o  = 1'b1;
                stall_idex_o  = 1'b1;
                clear_exmem_o = 1'b1;
            end
            if (br_act) begin
                clear_ifid_o = 1'b1;
                clear_idex_o = 1'b1;
            end
            if (lu_act) begin
                stall_pc_o   = 1'b1;
                stall_ifid_o = 1'b1;
                clear_idex_o = 1'b1;
            end
            mc_kill_o    = trap_req_i && ((state_q == S_MC_WAIT) || ex_mc_start_i);
            mc_timeout_o = mc_expire;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_flush_q;
    logic              flush_evt;

    // a trap already being flushed only restarts the flush, it is not a new event
    assign flush_evt = br_act || (trap_req_i && !in_flush);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_pc_o && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + PERF_W'(1);
            if (flush_evt && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + PERF_W'(1);
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`else
    assign perf_stall_cnt_o = '0;
    assign perf_flush_cnt_o = '0;
`endif

endmodule
